// File: rtl/usbfs_pkg.sv
// Shared definitions for the USB full-speed packet path: PID codes, the
// transmit state encoding and the serial CRC step functions (TX and RX).
package usbfs_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'h8005;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TXPID   = 3'd1,
        ST_TXTOK   = 3'd2,
        ST_TXDATA  = 3'd3,
        ST_TXCRC5  = 3'd4,
        ST_TXCRC16 = 3'd5,
        ST_TXFIN   = 3'd6
    } tx_state_e;

    // Token-class PIDs (OUT/IN/SOF/SETUP) share pid[1:0] = 01.
    function automatic logic pid_is_token(input logic [3:0] pid);
        return pid[1:0] == PID_OUT[1:0];
    endfunction

    // Data-class PIDs (DATA0/DATA1) share pid[1:0] = 11.
    function automatic logic pid_is_data(input logic [3:0] pid);
        return pid[1:0] == PID_DATA0[1:0];
    endfunction

    // One serial CRC5 step; data enters LSB first, register kept MSB-aligned.
    function automatic logic [4:0] CRC5_step(input logic [4:0] crc, input logic din);
        return {crc[3:0], 1'b0} ^ ((crc[4] ^ din) ? CRC5_POLY : 5'h00);
    endfunction

    // One serial CRC16 step; same bit ordering as CRC5_step.
    function automatic logic [15:0] CRC16_step(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/usbfs_crc_gen.sv
// Bit-serial CRC5/CRC16 generator. init reloads both registers; step folds
// din into the selected CRC; cpl inverts the result (applied after a step
// issued in the same cycle, so the last data bit and the final inversion
// can coincide). The RX checker drives the same controls.
module usbfs_crc_gen
    import usbfs_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        din,
    input  logic        step5,
    input  logic        cpl5,
    input  logic        step16,
    input  logic        cpl16,
    output logic [4:0]  crc5,
    output logic [15:0] crc16
);

    logic [4:0]  crc5_nxt;
    logic [15:0] crc16_nxt;

    // Next CRC values: optional step, then optional complement.
    always_comb begin
        crc5_nxt  = crc5;
        crc16_nxt = crc16;
        if (step5) begin
            crc5_nxt = CRC5_step(crc5, din);
        end
        if (cpl5) begin
            crc5_nxt = ~crc5_nxt;
        end
        if (step16) begin
            crc16_nxt = CRC16_step(crc16, din);
        end
        if (cpl16) begin
            crc16_nxt = ~crc16_nxt;
        end
    end

    // CRC registers; init has priority over step/complement.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc5  <= CRC5_INIT;
            crc16 <= CRC16_INIT;
        end else if (init) begin
            crc5  <= CRC5_INIT;
            crc16 <= CRC16_INIT;
        end else begin
            crc5  <= crc5_nxt;
            crc16 <= crc16_nxt;
        end
    end

endmodule

// File: rtl/usbfs_packet_tx_gen.sv
// USB full-speed packet sender. Serialises PID, token+CRC5, data+CRC16 or a
// bare handshake LSB first onto the bit-level tx_req/tx_bit/tx_fin interface
// toward the bit-stuffing/NRZI driver. Data bytes are pulled one at a time
// from the transaction layer with tp_byte_req.
module usbfs_packet_tx_gen
    import usbfs_pkg::*;
#(
    parameter bit HOST_EN = 1'b1,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tp_sta,
    input  logic [3:0]       tp_pid,
    input  logic [10:0]      tp_token,
    output logic             tp_byte_req,
    input  logic [7:0]       tp_byte,
    input  logic             tp_fin_n,
    output logic             tp_busy,
    output logic [LEN_W-1:0] tp_len,
    output logic             tp_err,
    output logic             tx_sta,
    input  logic             tx_req,
    output logic             tx_bit,
    output logic             tx_fin
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    tx_state_e   state;
    logic [3:0]  cnt;
    logic [7:0]  pid8;
    logic [10:0] tok11;
    logic [7:0]  byte_hold;
    logic        have_byte;
    // High on the cycle the transaction layer answers a byte request.
    logic        smp_vld_p1;

    logic        pid_legal;
    logic        len_full;
    logic        crc_din;
    logic        crc_step5;
    logic        crc_cpl5;
    logic        crc_step16;
    logic        crc_cpl16;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic [2:0]  c5_idx;
    logic [3:0]  c16_idx;

    assign pid_legal = HOST_EN || !pid_is_token(tp_pid);
    assign tx_sta    = tp_sta && (state == ST_IDLE) && pid_legal;
    assign len_full  = (tp_len == LEN_MAX);

    // CRC fields go out MSB first while cnt counts up.
    assign c5_idx  = 3'(4'd4 - cnt);
    assign c16_idx = 4'd15 - cnt;

    assign crc_din    = (state == ST_TXTOK) ? tok11[cnt] : byte_hold[cnt[2:0]];
    assign crc_step5  = (state == ST_TXTOK) && tx_req;
    assign crc_cpl5   = crc_step5 && (cnt == 4'd10);
    assign crc_step16 = (state == ST_TXDATA) && !smp_vld_p1 && tx_req && have_byte;
    assign crc_cpl16  = (state == ST_TXDATA) && smp_vld_p1 && (!tp_fin_n || len_full);

    usbfs_crc_gen u_crc (
        .clk    (clk),
        .rstn   (rstn),
        .init   (tx_sta),
        .din    (crc_din),
        .step5  (crc_step5),
        .cpl5   (crc_cpl5),
        .step16 (crc_step16),
        .cpl16  (crc_cpl16),
        .crc5   (crc5),
        .crc16  (crc16)
    );

    // Packet payload capture; pure data, reloaded before every use.
    always_ff @(posedge clk) begin
        if (tx_sta) begin
            pid8  <= {~tp_pid, tp_pid};
            tok11 <= tp_token;
        end
        if ((state == ST_TXDATA) && smp_vld_p1) begin
            byte_hold <= tp_byte;
        end
    end

    // Transmit sequencer with registered handshake and line outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            have_byte   <= 1'b0;
            smp_vld_p1  <= 1'b0;
            tp_byte_req <= 1'b0;
            tp_busy     <= 1'b0;
            tp_len      <= '0;
            tp_err      <= 1'b0;
            tx_bit      <= 1'b0;
            tx_fin      <= 1'b0;
        end else begin
            tp_byte_req <= 1'b0;
            tp_err      <= 1'b0;
            tx_bit      <= 1'b0;
            tx_fin      <= 1'b0;
            smp_vld_p1  <= tp_byte_req;
            case (state)
                ST_IDLE: begin
                    if (tx_fin) begin
                        tp_busy <= 1'b0;
                    end
                    if (tp_sta) begin
                        if (pid_legal) begin
                            state   <= ST_TXPID;
                            cnt     <= 4'd0;
                            tp_len  <= '0;
                            tp_busy <= 1'b1;
                        end else begin
                            tp_err <= 1'b1;
                        end
                    end
                end
                ST_TXPID: begin
                    if (tx_req) begin
                        tx_bit <= pid8[cnt[2:0]];
                        if (cnt == 4'd7) begin
                            cnt <= 4'd0;
                            if (pid_is_token(pid8[3:0])) begin
                                state <= ST_TXTOK;
                            end else if (pid_is_data(pid8[3:0])) begin
                                state       <= ST_TXDATA;
                                have_byte   <= 1'b0;
                                tp_byte_req <= 1'b1;
                            end else begin
                                state <= ST_TXFIN;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_TXTOK: begin
                    if (tx_req) begin
                        tx_bit <= tok11[cnt];
                        if (cnt == 4'd10) begin
                            cnt   <= 4'd0;
                            state <= ST_TXCRC5;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_TXCRC5: begin
                    if (tx_req) begin
                        tx_bit <= crc5[c5_idx];
                        if (cnt == 4'd4) begin
                            cnt   <= 4'd0;
                            state <= ST_TXFIN;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_TXDATA: begin
                    // The answer cycle owns the state; a tx_req here is dropped.
                    if (smp_vld_p1) begin
                        cnt <= 4'd0;
                        if (!tp_fin_n) begin
                            state <= ST_TXCRC16;
                        end else if (len_full) begin
                            state  <= ST_TXCRC16;
                            tp_err <= 1'b1;
                        end else begin
                            have_byte <= 1'b1;
                        end
                    end else if (tx_req && have_byte) begin
                        tx_bit <= byte_hold[cnt[2:0]];
                        if (cnt == 4'd7) begin
                            cnt         <= 4'd0;
                            have_byte   <= 1'b0;
                            tp_len      <= tp_len + LEN_W'(1);
                            tp_byte_req <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_TXCRC16: begin
                    if (tx_req) begin
                        tx_bit <= crc16[c16_idx];
                        if (cnt == 4'd15) begin
                            cnt   <= 4'd0;
                            state <= ST_TXFIN;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_TXFIN: begin
                    if (tx_req) begin
                        tx_fin <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usbfs_packet_tx_gen.sv
// Bench for usbfs_packet_tx_gen: instance 0 is host-capable with 64-byte
// payloads, instance 1 is device-only with a 2-byte payload limit.
module tb_usbfs_packet_tx_gen;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] sta;
    logic [1:0] txreq;
    logic [1:0] req_d;
    logic [3:0] pid;
    logic [10:0] tok;
    logic [7:0] tp_byte;
    logic       fin_n;

    wire [1:0] byte_req, busy, err, txsta, txbit, txfin;
    wire [9:0] len_a, len_b;

    int exp_q[$];
    logic [7:0] byte_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_err[2];
    int n_breq[2];

    usbfs_packet_tx_gen #(.HOST_EN(1'b1), .MAX_LEN(64), .LEN_W(10)) dut_a (
        .clk(clk), .rstn(rstn), .tp_sta(sta[0]), .tp_pid(pid), .tp_token(tok),
        .tp_byte_req(byte_req[0]), .tp_byte(tp_byte), .tp_fin_n(fin_n),
        .tp_busy(busy[0]), .tp_len(len_a), .tp_err(err[0]), .tx_sta(txsta[0]),
        .tx_req(txreq[0]), .tx_bit(txbit[0]), .tx_fin(txfin[0])
    );

    usbfs_packet_tx_gen #(.HOST_EN(1'b0), .MAX_LEN(2), .LEN_W(10)) dut_b (
        .clk(clk), .rstn(rstn), .tp_sta(sta[1]), .tp_pid(pid), .tp_token(tok),
        .tp_byte_req(byte_req[1]), .tp_byte(tp_byte), .tp_fin_n(fin_n),
        .tp_busy(busy[1]), .tp_len(len_b), .tp_err(err[1]), .tx_sta(txsta[1]),
        .tx_req(txreq[1]), .tx_bit(txbit[1]), .tx_fin(txfin[1])
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Expected line events: 0/1 = data bit, 2 = tx_fin alone.
    task automatic push_bits(input logic [15:0] v, input int n, input bit msb_first);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(msb_first ? int'(v[n-1-i]) : int'(v[i]));
        end
    endtask

    task automatic push_fin();
        exp_q.push_back(2);
    endtask

    // Reference USB data CRC: reflected register, shift right, poly 0xA001.
    // The returned value is the inverted remainder, transmitted LSB first.
    function automatic logic [15:0] crc16_wire(input logic [31:0] data, input int nbytes);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 8 * nbytes; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
            else                c = c >> 1;
        end
        return ~c;
    endfunction

    always @(posedge clk) req_d <= txreq;

    // Monitor: one expected event per tx_req; quiet line otherwise.
    initial begin
        int got;
        int e;
        n_err[0] = 0; n_err[1] = 0; n_breq[0] = 0; n_breq[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (err[d]) n_err[d]++;
                if (byte_req[d]) n_breq[d]++;
                got = int'({txfin[d], txbit[d]});
                if (req_d[d]) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    check($sformatf("tx_event[%0d]", d), got, e);
                end else begin
                    check($sformatf("tx_idle[%0d]", d), got, 0);
                end
            end
        end
    end

    // Transaction-layer model: answers each byte request on the next cycle,
    // then scrambles the bus so the DUT must rely on its own copy.
    initial begin
        tp_byte = 8'h00;
        fin_n   = 1'b0;
        forever begin
            @(negedge clk);
            if (|byte_req) begin
                @(posedge clk); #1;
                if (byte_q.size() > 0) begin
                    fin_n   = 1'b1;
                    tp_byte = byte_q.pop_front();
                end else begin
                    fin_n   = 1'b0;
                    tp_byte = 8'hEE;
                end
                @(posedge clk); #1;
                tp_byte = ~tp_byte;
                fin_n   = 1'b0;
            end
        end
    end

    task automatic send(input int d, input logic [3:0] p, input logic [10:0] t,
                        input int nreq, input bit legal);
        @(posedge clk); #1;
        pid = p; tok = t; sta[d] = 1'b1;
        #1 check($sformatf("tx_sta[%0d]", d), int'(txsta[d]), int'(legal));
        @(posedge clk); #1;
        sta[d] = 1'b0;
        for (int i = 0; i < nreq; i++) begin
            repeat (3) @(posedge clk);
            #1 txreq[d] = 1'b1;
            @(posedge clk);
            #1 txreq[d] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d);
        int t;
        t = 0;
        while (busy[d] && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1 check($sformatf("busy_end[%0d]", d), int'(busy[d]), 0);
    endtask

    task automatic run_pkt(input string nm, input int d, input logic [3:0] p,
                           input logic [10:0] t, input int exp_len,
                           input int exp_err, input int exp_breq);
        int e0, b0, nreq;
        e0 = n_err[d]; b0 = n_breq[d]; nreq = exp_q.size();
        send(d, p, t, nreq, 1'b1);
        wait_idle(d);
        check({nm, "_len"}, d ? int'(len_b) : int'(len_a), exp_len);
        check({nm, "_err"}, n_err[d] - e0, exp_err);
        check({nm, "_breq"}, n_breq[d] - b0, exp_breq);
        check({nm, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int e0, b0;
        sta = 2'b00; txreq = 2'b00; pid = 4'h0; tok = 11'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_len_a", int'(len_a), 0);
        check("rst_len_b", int'(len_b), 0);
        check("rst_err", int'(err), 0);
        check("rst_breq", int'(byte_req), 0);
        check("rst_line", int'({txfin, txbit}), 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // ACK: PID byte 0xD2.
        push_bits(16'h00D2, 8, 1'b0); push_fin();
        run_pkt("ack", 0, 4'h2, 11'h0, 0, 0, 0);

        // DATA0, empty payload: PID 0xC3, inverted FFFF = all zeros.
        push_bits(16'h00C3, 8, 1'b0); push_bits(16'h0000, 16, 1'b1); push_fin();
        run_pkt("data0_zlp", 0, 4'h3, 11'h0, 0, 0, 1);

        // DATA1 00 01 02 03: PID 0x4B, CRC field 0xF75E sent MSB first.
        byte_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        push_bits(16'h004B, 8, 1'b0);
        for (int i = 0; i < 4; i++) push_bits(16'(i), 8, 1'b0);
        push_bits(16'hF75E, 16, 1'b1); push_fin();
        run_pkt("data1_4b", 0, 4'hB, 11'h0, 4, 0, 5);

        // SETUP addr 0x15 endp 0xE: PID 0x2D, token 0x715, CRC5 10111.
        push_bits(16'h002D, 8, 1'b0); push_bits(16'h0715, 11, 1'b0);
        push_bits(16'h0017, 5, 1'b1); push_fin();
        run_pkt("setup", 0, 4'hD, 11'h715, 0, 0, 0);

        // SOF frame 0x710: PID 0xA5, CRC5 10100.
        push_bits(16'h00A5, 8, 1'b0); push_bits(16'h0710, 11, 1'b0);
        push_bits(16'h0014, 5, 1'b1); push_fin();
        run_pkt("sof", 0, 4'h5, 11'h710, 0, 0, 0);

        // Device-only instance rejects OUT.
        e0 = n_err[1]; b0 = n_breq[1];
        send(1, 4'h1, 11'h0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_busy", int'(busy[1]), 0);
        check("illegal_err", n_err[1] - e0, 1);
        check("illegal_breq", n_breq[1] - b0, 0);

        // MAX_LEN=2 with three bytes offered: third byte dropped, tp_err.
        byte_q = '{8'h11, 8'h22, 8'h33};
        push_bits(16'h00C3, 8, 1'b0);
        push_bits(16'h0011, 8, 1'b0); push_bits(16'h0022, 8, 1'b0);
        push_bits(crc16_wire(32'h0000_2211, 2), 16, 1'b0); push_fin();
        run_pkt("trunc", 1, 4'h3, 11'h0, 2, 1, 3);
        check("trunc_byte_q", byte_q.size(), 0);

        // Reset in the middle of the second data byte.
        byte_q = '{8'hA5, 8'h3C};
        push_bits(16'h004B, 8, 1'b0); push_bits(16'h00A5, 8, 1'b0);
        push_bits(16'h0000, 2, 1'b0);
        send(0, 4'hB, 11'h0, 18, 1'b1);
        #1 check("mid_len", int'(len_a), 1);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy[0]), 0);
        check("mid_rst_len", int'(len_a), 0);
        check("mid_rst_line", int'({txfin[0], txbit[0]}), 0);
        check("mid_rst_left", exp_q.size(), 0);
        byte_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Clean DATA0 with one byte after the abort.
        byte_q = '{8'h5A};
        push_bits(16'h00C3, 8, 1'b0); push_bits(16'h005A, 8, 1'b0);
        push_bits(crc16_wire(32'h0000_005A, 1), 16, 1'b0); push_fin();
        run_pkt("post_rst", 0, 4'h3, 11'h0, 1, 0, 2);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
